// File: rtl/pause_dim_ctrl.sv
// pause_dim_ctrl: merges pause sources into one registered pause_cpu and
// attenuates the RGB stream after a programmable paused idle time.
// Optional macro PAUSE_FADE_EN: stepped fade 1->2->3 instead of a jump to 2.
module pause_dim_ctrl #(
    parameter int RW       = 4,
    parameter int GW       = 4,
    parameter int BW       = 4,
    parameter int CLK_KHZ  = 48000,
    parameter int DIM_SECS = 10,
    parameter int NREQ     = 2
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                user_button,
    input  logic [NREQ-1:0]     pause_request,
    input  logic                OSD_STATUS,
    input  logic [1:0]          options,
    input  logic [RW+GW+BW-1:0] rgb_in,
    output logic                pause_cpu,
    output logic                dim_active,
    output logic [RW+GW+BW-1:0] rgb_out
);
    localparam int PW        = RW + GW + BW;
    localparam int MSW       = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;
    localparam int SEC_LIMIT = DIM_SECS * 1000;
    localparam int SW        = $clog2(SEC_LIMIT + 1);
    localparam logic [MSW-1:0] MS_LAST = MSW'(CLK_KHZ - 1);
    localparam logic [SW-1:0]  SEC_MAX = SW'(SEC_LIMIT);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PAUSED = 2'd1;
    localparam logic [1:0] ST_DIMMED = 2'd2;

    logic           btn_q, btn_d;
    logic           user_pause_q, user_pause_d;
    logic           pause_cpu_q, pause_cpu_d;
    logic           dim_active_q, dim_active_d;
    logic [PW-1:0]  rgb_out_q, rgb_out_d;
    logic [MSW-1:0] ms_cnt_q, ms_cnt_d;
    logic [SW-1:0]  sec_cnt_q, sec_cnt_d;
    logic [1:0]     level_q, level_d;
    logic [1:0]     state;
    logic           run, tick, sec_sat;
    logic [2:0]     mul;
    logic [RW+1:0]  r_prod;
    logic [GW+1:0]  g_prod;
    logic [BW+1:0]  b_prod;
`ifdef PAUSE_FADE_EN
    localparam logic [7:0] FADE_LAST = 8'd249;
    logic [7:0]     fade_cnt_q, fade_cnt_d;
`endif

    // Pause merge: the button toggle feeds pause_cpu through its next state
    always_comb begin
        btn_d        = user_button;
        user_pause_d = user_pause_q ^ (user_button & ~btn_q);
        pause_cpu_d  = user_pause_d | (|pause_request) | (OSD_STATUS & options[0]);
    end

    // Timer and level: counters advance in step with the pause_cpu register,
    // so any unpause clears them on the same edge that drops pause_cpu
    always_comb begin
        run     = pause_cpu_d & options[1];
        tick    = run && (ms_cnt_q == MS_LAST);
        sec_sat = (sec_cnt_q == SEC_MAX);
        if (!pause_cpu_d)  state = ST_RUN;
        else if (sec_sat)  state = ST_DIMMED;
        else               state = ST_PAUSED;

        ms_cnt_d  = ms_cnt_q;
        sec_cnt_d = sec_cnt_q;
        level_d   = level_q;
`ifdef PAUSE_FADE_EN
        fade_cnt_d = fade_cnt_q;
`endif
        if (!run) begin
            ms_cnt_d  = '0;
            sec_cnt_d = '0;
            level_d   = 2'd0;
`ifdef PAUSE_FADE_EN
            fade_cnt_d = '0;
`endif
        end else begin
            ms_cnt_d = tick ? '0 : ms_cnt_q + MSW'(1);
            if (tick && !sec_sat)
                sec_cnt_d = sec_cnt_q + SW'(1);
            case (state)
                ST_DIMMED: begin
`ifdef PAUSE_FADE_EN
                    // First dimmed cycle enters level 1, then one step per 250 ticks
                    if (level_q == 2'd0) begin
                        level_d    = 2'd1;
                        fade_cnt_d = '0;
                    end else if (level_q != 2'd3 && tick) begin
                        if (fade_cnt_q == FADE_LAST) begin
                            level_d    = level_q + 2'd1;
                            fade_cnt_d = '0;
                        end else begin
                            fade_cnt_d = fade_cnt_q + 8'd1;
                        end
                    end
`else
                    level_d = 2'd2;
`endif
                end
                default: level_d = level_q;
            endcase
        end
    end

    // Attenuation: c*(4-level)>>2 per channel, using the level taking effect now
    always_comb begin
        mul          = 3'd4 - {1'b0, level_d};
        r_prod       = {2'b00, rgb_in[PW-1 -: RW]} * (RW+2)'(mul);
        g_prod       = {2'b00, rgb_in[GW+BW-1 -: GW]} * (GW+2)'(mul);
        b_prod       = {2'b00, rgb_in[BW-1:0]} * (BW+2)'(mul);
        rgb_out_d    = {r_prod[RW+1:2], g_prod[GW+1:2], b_prod[BW+1:2]};
        dim_active_d = (level_d != 2'd0);
    end

    // State registers; btn_q resets high so a button held through reset is ignored
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            btn_q        <= 1'b1;
            user_pause_q <= 1'b0;
            pause_cpu_q  <= 1'b0;
            dim_active_q <= 1'b0;
            rgb_out_q    <= '0;
            ms_cnt_q     <= '0;
            sec_cnt_q    <= '0;
            level_q      <= 2'd0;
`ifdef PAUSE_FADE_EN
            fade_cnt_q   <= '0;
`endif
        end else begin
            btn_q        <= btn_d;
            user_pause_q <= user_pause_d;
            pause_cpu_q  <= pause_cpu_d;
            dim_active_q <= dim_active_d;
            rgb_out_q    <= rgb_out_d;
            ms_cnt_q     <= ms_cnt_d;
            sec_cnt_q    <= sec_cnt_d;
            level_q      <= level_d;
`ifdef PAUSE_FADE_EN
            fade_cnt_q   <= fade_cnt_d;
`endif
        end
    end

    assign pause_cpu  = pause_cpu_q;
    assign dim_active = dim_active_q;
    assign rgb_out    = rgb_out_q;
endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Bench for pause_dim_ctrl: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a count-based model.
module tb_pause_dim_ctrl;
    localparam int K     = 1;     // CLK_KHZ: one ms per cycle
    localparam int LIMIT = 1000;  // DIM_SECS=1 -> 1000 ms ticks

    logic        clk_sys = 1'b0;
    logic        reset, user_button, OSD_STATUS;
    logic [1:0]  pause_request, options;
    logic [11:0] rgb_in, rgb_out;
    logic        pause_cpu, dim_active;

    int checks = 0, failures = 0;
    bit chk_en = 0;

    // model state (values as seen after the latest edge)
    bit          m_btn, m_up, m_pause, m_dim;
    logic [11:0] m_rgb;
    int          m_runc, m_lvl, m_fade;

    pause_dim_ctrl #(.RW(4), .GW(4), .BW(4), .CLK_KHZ(K), .DIM_SECS(1), .NREQ(2)) dut (
        .clk_sys(clk_sys), .reset(reset), .user_button(user_button),
        .pause_request(pause_request), .OSD_STATUS(OSD_STATUS), .options(options),
        .rgb_in(rgb_in), .pause_cpu(pause_cpu), .dim_active(dim_active), .rgb_out(rgb_out));

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] atten(input logic [11:0] p, input int l);
        int r, g, b;
        r = int'(p[11:8]) * (4 - l) / 4;
        g = int'(p[7:4])  * (4 - l) / 4;
        b = int'(p[3:0])  * (4 - l) / 4;
        return {r[3:0], g[3:0], b[3:0]};
    endfunction

    // Reference model: timer expressed as a count of consecutive paused cycles
    initial forever begin
        bit p_next, run, tick;
        int sec;
        @(posedge clk_sys);
        if (reset) begin
            m_btn = 1; m_up = 0; m_pause = 0; m_dim = 0; m_rgb = '0;
            m_runc = 0; m_lvl = 0; m_fade = 0;
        end else begin
            m_up   = m_up ^ (user_button & ~m_btn);
            m_btn  = user_button;
            p_next = m_up | (|pause_request) | (OSD_STATUS & options[0]);
            run    = p_next & options[1];
            tick   = run && (m_runc % K == K - 1);
            sec    = (m_runc / K < LIMIT) ? m_runc / K : LIMIT;
            if (!run) begin
                m_runc = 0; m_lvl = 0; m_fade = 0;
            end else begin
                if (sec == LIMIT) begin
`ifdef PAUSE_FADE_EN
                    if (m_lvl == 0) m_lvl = 1;
                    else if (tick) begin
                        m_fade++;
                        m_lvl = (1 + m_fade / 250 > 3) ? 3 : 1 + m_fade / 250;
                    end
`else
                    m_lvl = 2;
`endif
                end
                m_runc++;
            end
            m_pause = p_next;
            m_dim   = (m_lvl != 0);
            m_rgb   = atten(rgb_in, m_lvl);
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk_sys);
        if (chk_en) begin
            check("pause_cpu", 32'(pause_cpu), 32'(m_pause));
            check("dim_active", 32'(dim_active), 32'(m_dim));
            check("rgb_out", 32'(rgb_out), 32'(m_rgb));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    initial begin
        reset = 1; user_button = 1; OSD_STATUS = 0;
        pause_request = 2'b00; options = 2'b00; rgb_in = 12'h000;
        @(posedge clk_sys);
        chk_en = 1;
        cyc(3);
        check("rst_pause", 32'(pause_cpu), 32'd0);
        check("rst_dim", 32'(dim_active), 32'd0);
        check("rst_rgb", 32'(rgb_out), 32'h0);

        // button held through reset: no toggle
        reset = 0;
        cyc(3);
        check("held_btn_no_toggle", 32'(pause_cpu), 32'd0);
        user_button = 0; cyc(2);
        user_button = 1; cyc(1);
        check("btn_toggle_on", 32'(pause_cpu), 32'd1);
        user_button = 0; cyc(1);
        user_button = 1; cyc(1);
        check("btn_toggle_off", 32'(pause_cpu), 32'd0);
        user_button = 0;

        // request-driven pause with dimming
        pause_request = 2'b10; options = 2'b10; rgb_in = 12'hFFF;
        cyc(1);
        check("req_pause", 32'(pause_cpu), 32'd1);
        cyc(999);
        check("pre_dim_rgb", 32'(rgb_out), 32'hFFF);
        check("pre_dim_flag", 32'(dim_active), 32'd0);
        cyc(1);
        check("dim_flag", 32'(dim_active), 32'd1);
`ifdef PAUSE_FADE_EN
        check("fade_l1", 32'(rgb_out), 32'hBBB);
        cyc(250);
        check("fade_l2", 32'(rgb_out), 32'h777);
        cyc(250);
        check("fade_l3", 32'(rgb_out), 32'h333);
        cyc(20);
        check("fade_hold", 32'(rgb_out), 32'h333);
`else
        check("dim_rgb", 32'(rgb_out), 32'h777);
        cyc(300);
        check("dim_hold", 32'(rgb_out), 32'h777);
`endif

        // unpause from dimmed: immediate restore, re-pause restarts count
        pause_request = 2'b00; rgb_in = 12'h5A3;
        cyc(1);
        check("unpause_pause", 32'(pause_cpu), 32'd0);
        check("unpause_dim", 32'(dim_active), 32'd0);
        check("unpause_rgb", 32'(rgb_out), 32'h5A3);
        pause_request = 2'b01;
        cyc(1000);
        check("repause_nodim", 32'(dim_active), 32'd0);
        cyc(1);
        check("repause_dim", 32'(dim_active), 32'd1);
`ifndef PAUSE_FADE_EN
        check("repause_rgb", 32'(rgb_out), 32'h251);
`endif

        // OSD pause gated by options[0]
        pause_request = 2'b00; options = 2'b00; OSD_STATUS = 1;
        cyc(3);
        check("osd_ignored", 32'(pause_cpu), 32'd0);
        options = 2'b01;
        cyc(1);
        check("osd_pause", 32'(pause_cpu), 32'd1);

        // reset while dimmed
        options = 2'b11; rgb_in = 12'hFFF;
        cyc(1005);
        check("pre_reset_dim", 32'(dim_active), 32'd1);
        reset = 1;
        cyc(1);
        check("reset_rgb", 32'(rgb_out), 32'h0);
        check("reset_pause", 32'(pause_cpu), 32'd0);
        reset = 0;
        cyc(1000);
        check("post_reset_nodim", 32'(dim_active), 32'd0);
        cyc(1);
        check("post_reset_dim", 32'(dim_active), 32'd1);

        // randomized phase, model-checked every cycle
        OSD_STATUS = 0; options = 2'b10;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk_sys);
            rgb_in = 12'($urandom);
            if ($urandom_range(0, 15) == 0) user_button = ~user_button;
            if ($urandom_range(0, 399) == 0) pause_request[0] = ~pause_request[0];
            if ($urandom_range(0, 399) == 0) pause_request[1] = ~pause_request[1];
            if ($urandom_range(0, 499) == 0) OSD_STATUS = ~OSD_STATUS;
            if ($urandom_range(0, 799) == 0) options = 2'($urandom);
            reset = ($urandom_range(0, 2999) == 0);
        end
        reset = 0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
